// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the OPL3 register file: two requesters, one-cycle
// write strobe, then a fixed recovery window before the next grant.
module reg_write_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int WRITE_GAP  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_bank,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_bank,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr,
  output logic                  bank_select,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  last_grant,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CNT_W = $clog2(WRITE_GAP);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WRITE_GAP - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  can_grant;

  // Handshake: a transfer happens in a cycle where reqi_valid && reqi_ready.
  // Ready depends on valid; requesters hold valid and payload until ready.
  // The reset_n term keeps both readies low while reset is asserted.
  always_comb begin
    can_grant  = reset_n && (state_q == IDLE);
    req0_ready = can_grant && req0_valid && (!ptr_q || !req1_valid);
    req1_ready = can_grant && req1_valid && (ptr_q || !req0_valid);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          state_d = WRITE;
          bank_d  = req0_bank;
          addr_d  = req0_address;
          data_d  = req0_data;
          last_d  = 1'b0;
          ptr_d   = 1'b1;
        end else if (req1_ready) begin
          state_d = WRITE;
          bank_d  = req1_bank;
          addr_d  = req1_address;
          data_d  = req1_data;
          last_d  = 1'b1;
          ptr_d   = 1'b0;
        end
      end
      WRITE: begin
        cnt_d   = GAP_LOAD;
        state_d = HOLD;
      end
      HOLD: begin
        // Counter reaching zero ends the recovery window: HOLD spans WRITE_GAP-1 cycles.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    wr          = (state_q == WRITE);
    busy        = (state_q != IDLE);
    bank_select = bank_q;
    address     = addr_q;
    wr_data     = data_q;
    last_grant  = last_q;
    dbg_state   = state_q;
  end

endmodule
